mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Block-copy initiator for the 8-bit data memory: on a single `Start` pulse it reads `Length` bytes from `SrcAddr` onward and writes them to `DstAddr` onward. It drives the memory's read/write strobes, address and write data, and captures its combinational read data. It sits beside the CPU on the data-memory port. A top-level mux grants it the port while `Busy` is high.

## Interface
Parameters:
- `ADDR_W`, default 8: memory address width; 2^ADDR_W bytes.
- `DATA_W`, default 8: byte width.

Ports:
- `clk` input 1: single clock; all state changes on posedge.
- `Reset` input 1: synchronous, active-high reset.
- `Start` input 1: request pulse; sampled only in IDLE.
- `SrcAddr` input ADDR_W: first source address; latched on accepted Start.
- `DstAddr` input ADDR_W: first destination address; latched on accepted Start.
- `Length` input ADDR_W+1: byte count, 0..2^ADDR_W; latched on accepted Start.
- `Busy` output 1: high in READ and WRITE.
- `Done` output 1: one-cycle completion pulse.
- `MemRead` output 1: memory read strobe.
- `MemWrite` output 1: memory write strobe.
- `MemAddress` output ADDR_W: memory address.
- `MemWData` output DATA_W: write data to memory.
- `MemRData` input DATA_W: combinational read data from memory, valid in the same cycle as `MemRead`.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - `Start`=1 latches the source address, destination address and length, and clears the byte index.
  - Length≠0 → READ. Length=0 → DONE.
- READ:
  - `MemRead`=1, `MemAddress`=src+idx.
  - `MemRData` is captured into the byte buffer at the clock edge.
  - Always → WRITE.
- WRITE:
  - `MemWrite`=1, `MemAddress`=dst+idx, `MemWData`=buffer.
  - idx increments at the edge.
  - If idx+1 = length → DONE, otherwise → READ.
- DONE: `Done`=1 for exactly one cycle, then → IDLE.
- Strobes:
  - `MemRead` and `MemWrite` are never high together.
  - Both are 0 in IDLE and DONE, where `MemAddress` and `MemWData` are driven 0.
- Address arithmetic is modulo 2^ADDR_W; both src+idx and dst+idx wrap from 255 to 0.
- The index counter is ADDR_W+1 bits, so Length=256 copies the whole memory.
- `Start` in READ, WRITE or DONE is ignored and not queued.
- Copy direction is ascending only.
  - For overlapping regions with src < dst < src+len, the result is defined as the byte-by-byte forward copy: source bytes are overwritten before they are read.
  - Any other overlap produces a correct copy.
- Reset mid-operation:
  - Next state is IDLE.
  - Bytes already written stay written.
  - No `Done` pulse is produced.

## Timing
- Reset values: `Busy`=0, `Done`=0, `MemRead`=0, `MemWrite`=0, `MemAddress`=0, `MemWData`=0; state=IDLE, index=0, buffer=0.
- All outputs are decoded from registered state, index and buffer; there is no combinational path from `Start` to any output.
- Start accepted at edge T:
  - The first READ is cycle T+1 and the first WRITE is T+2.
  - Byte k is read in cycle T+1+2k and written in cycle T+2+2k.
  - `Done` is high in cycle T+1+2·Length.
  - For Length=0, `Done` is high in cycle T+1.
- Throughput is 2 cycles per byte. The earliest next Start is accepted in the cycle after `Done`.

## Configuration
- Macro: `MEM_COPY_FILL_EN`.
- Defined:
  - Adds ports `Fill` (input 1) and `FillValue` (input DATA_W), both latched on an accepted Start.
  - With `Fill`=1 the READ state is skipped: IDLE → WRITE directly, and WRITE → WRITE until the last byte.
  - `MemWData`=FillValue, so throughput is 1 byte per cycle.
  - `Done` is high in cycle T+1+Length.
  - `SrcAddr` is ignored in fill mode.
- Undefined: the ports are absent and the block is a copy-only engine exactly as described above.

## Structure
- Package `mem_copy_pkg` contains:
  - `mem_copy_state_t` enum {IDLE, READ, WRITE, DONE};
  - the default `ADDR_W`/`DATA_W` localparams;
  - a `mem_copy_req_t` struct {src, dst, len[, fill, fill_value]} used for the latched request.
- Single module, no sub-modules.
- The bench instantiates the existing data memory as the responder.

## Test plan
- Basic copy:
  - Preload mem[0x10..0x13]=A1,B2,C3,D4. Start src=0x10, dst=0x40, len=4.
  - Expect mem[0x40..0x43]=A1,B2,C3,D4 and `Done` in cycle T+9.
  - `Busy` is high for cycles T+1..T+8.
- Zero length: len=0 → `Done` in cycle T+1; no `MemRead`/`MemWrite` asserted; memory unchanged.
- Wrap-around:
  - Setup: src=0xFE, dst=0x02, len=4, with mem[FE,FF,00,01]=11,22,33,44.
  - Expect mem[02..05]=11,22,33,44.
  - The read address sequence is FE,FF,00,01.
- Start while busy: a second Start at T+3 with different parameters is ignored; exactly one `Done`, and only the first copy happens.
- Reset mid-copy:
  - Start len=8 and assert `Reset` at T+5.
  - Expect only bytes 0 and 1 written, all outputs 0 from the next cycle, no `Done`, and a new Start accepted normally.
- Fill mode (`MEM_COPY_FILL_EN` defined): Fill=1, FillValue=0x5A, dst=0x80, len=3 → mem[80..82]=5A, `MemRead` never high, `Done` in cycle T+4.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared types for the block-copy engine.
// Optional fill mode is compiled in with the MEM_COPY_FILL_EN macro.
package mem_copy_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 8;
    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } mem_copy_state_t;

    // Request captured on an accepted Start; field widths follow the default widths above.
    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] src;
        logic [DEFAULT_ADDR_W-1:0] dst;
        logic [DEFAULT_ADDR_W:0]   len;
`ifdef MEM_COPY_FILL_EN
        logic                      fill;
        logic [DEFAULT_DATA_W-1:0] fill_value;
`endif
    } mem_copy_req_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: request/status handshake plus the data-memory port of the copy engine.
// The Fill/FillValue request fields exist only when MEM_COPY_FILL_EN is defined.
interface mem_copy_engine_if #(
    parameter int unsigned ADDR_W = mem_copy_pkg::DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = mem_copy_pkg::DEFAULT_DATA_W
);

    // Request / status
    logic              Start;
    logic [ADDR_W-1:0] SrcAddr;
    logic [ADDR_W-1:0] DstAddr;
    logic [ADDR_W:0]   Length;
`ifdef MEM_COPY_FILL_EN
    logic              Fill;
    logic [DATA_W-1:0] FillValue;
`endif
    logic              Busy;
    logic              Done;

    // Data-memory port
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;

    // Engine side
    modport master (
        input  Start, SrcAddr, DstAddr, Length,
`ifdef MEM_COPY_FILL_EN
        input  Fill, FillValue,
`endif
        output Busy, Done,
        output MemRead, MemWrite, MemAddress, MemWData,
        input  MemRData
    );

    // Requester and memory side
    modport slave (
        output Start, SrcAddr, DstAddr, Length,
`ifdef MEM_COPY_FILL_EN
        output Fill, FillValue,
`endif
        input  Busy, Done,
        input  MemRead, MemWrite, MemAddress, MemWData,
        output MemRData
    );

endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: ascending byte-by-byte block copy over the data-memory port, two cycles per
// byte (READ then WRITE). Defining MEM_COPY_FILL_EN adds a fill mode that writes a constant
// value at one byte per cycle without reading.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic               clk,
    input  logic               Reset,
    mem_copy_engine_if.master  bus
);

    mem_copy_state_t   state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    mem_copy_req_t     req_q, req_d;

    logic [ADDR_W:0]   idx_inc;
    logic              last_byte;
    logic              fill_mode;
    logic              start_fill;
    logic [DATA_W-1:0] wr_data;

    assign idx_inc   = idx_q + (ADDR_W + 1)'(1);
    assign last_byte = (idx_inc == req_q.len);

`ifdef MEM_COPY_FILL_EN
    assign fill_mode  = req_q.fill;
    // The live Fill input picks the first state, since req_q only loads at the same edge.
    assign start_fill = bus.Fill;
    assign wr_data    = req_q.fill ? req_q.fill_value : buf_q;
`else
    assign fill_mode  = 1'b0;
    assign start_fill = 1'b0;
    assign wr_data    = buf_q;
`endif

    // State, index, byte buffer and latched request; synchronous reset abandons any copy.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            req_q   <= req_d;
        end
    end

    // Next-state logic: accept Start only in IDLE, alternate READ/WRITE until the last byte.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    req_d.src = bus.SrcAddr;
                    req_d.dst = bus.DstAddr;
                    req_d.len = bus.Length;
`ifdef MEM_COPY_FILL_EN
                    req_d.fill       = bus.Fill;
                    req_d.fill_value = bus.FillValue;
`endif
                    idx_d = '0;
                    if (bus.Length == '0) begin
                        state_d = DONE;
                    end else if (start_fill) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                buf_d   = bus.MemRData;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d = idx_inc;
                if (last_byte) begin
                    state_d = DONE;
                end else if (fill_mode) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only; address sums wrap modulo 2^ADDR_W.
    always_comb begin
        bus.Busy       = 1'b0;
        bus.Done       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.MemAddress = '0;
        bus.MemWData   = '0;
        unique case (state_q)
            READ: begin
                bus.Busy       = 1'b1;
                bus.MemRead    = 1'b1;
                bus.MemAddress = req_q.src + idx_q[ADDR_W-1:0];
            end
            WRITE: begin
                bus.Busy       = 1'b1;
                bus.MemWrite   = 1'b1;
                bus.MemAddress = req_q.dst + idx_q[ADDR_W-1:0];
                bus.MemWData   = wr_data;
            end
            DONE: begin
                bus.Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: copy engine against a behavioural byte memory; expected memory images
// come from a forward byte-copy model, expected timing from cycles-per-byte arithmetic.
// Fill-mode tests are compiled in with MEM_COPY_FILL_EN.
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic load;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Data memory responder: combinational read, write at the clock edge, bulk image load.
    logic [7:0] mem     [256];
    logic [7:0] img     [256];
    logic [7:0] exp_mem [256];

    assign bus.MemRData = mem[bus.MemAddress];

    always @(posedge clk) begin
        if (load) begin
            mem <= img;
        end else if (bus.MemWrite) begin
            mem[bus.MemAddress] <= bus.MemWData;
        end
    end

    // Bus activity counters, sampled mid-cycle.
    int         n_busy = 0, n_done = 0, n_rd = 0, n_wr = 0, n_both = 0;
    logic [7:0] rd_log [$];

    always @(negedge clk) begin
        if (bus.Busy) n_busy++;
        if (bus.Done) n_done++;
        if (bus.MemRead) begin
            n_rd++;
            rd_log.push_back(bus.MemAddress);
        end
        if (bus.MemWrite) n_wr++;
        if (bus.MemRead && bus.MemWrite) n_both++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic randomize_image();
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    endtask

    task automatic load_image();
        exp_mem = img;
        @(negedge clk);
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Reference: ascending byte-by-byte copy (or fill) with 8-bit address wrap.
    task automatic model_copy(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len,
                              input logic fill, input logic [7:0] fv);
        logic [7:0] sa, da;
        for (int k = 0; k < int'(len); k++) begin
            sa = src + 8'(k);
            da = dst + 8'(k);
            exp_mem[da] = fill ? fv : exp_mem[sa];
        end
    endtask

    task automatic compare_mem(input string name);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        check(name, bad, 0);
    endtask

    task automatic drive_start(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len,
                               input logic fill, input logic [7:0] fv);
        bus.Start   = 1'b1;
        bus.SrcAddr = src;
        bus.DstAddr = dst;
        bus.Length  = len;
`ifdef MEM_COPY_FILL_EN
        bus.Fill      = fill;
        bus.FillValue = fv;
`else
        if (fill) $display("note: fill requested in copy-only build (value %0h)", fv);
`endif
    endtask

    // Issue one request from IDLE, wait (bounded) for Done, report latency and activity deltas.
    task automatic do_copy(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len,
                           input logic fill, input logic [7:0] fv,
                           output int lat, output int busy_n, output int rd_n, output int wr_n,
                           output int both_n);
        int t, b0, r0, w0, x0;
        @(negedge clk);
        drive_start(src, dst, len, fill, fv);
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        t  = cyc;
        b0 = n_busy; r0 = n_rd; w0 = n_wr; x0 = n_both;
        lat = -1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin
                lat = cyc - t + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        busy_n = n_busy - b0;
        rd_n   = n_rd - r0;
        wr_n   = n_wr - w0;
        both_n = n_both - x0;
        model_copy(src, dst, len, fill, fv);
    endtask

    typedef struct {
        string      name;
        logic [7:0] src;
        logic [7:0] dst;
        logic [8:0] len;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat, busy_n, rd_n, wr_n, both_n, base, t, d0;
        logic [7:0] pat_a [4];
        logic [7:0] pat_w [4];
        logic [7:0] wrap_addr [4];
        logic [8:0] len;
        logic [7:0] src, dst, fv;
        logic       fill;
        int         e_lat, e_busy, e_rd;

        pat_a     = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        pat_w     = '{8'h11, 8'h22, 8'h33, 8'h44};
        wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};

        vecs[0] = '{"basic",      8'h10, 8'h40, 9'd4,   9};
        vecs[1] = '{"zero_len",   8'h20, 8'h30, 9'd0,   1};
        vecs[2] = '{"wrap",       8'hFE, 8'h02, 9'd4,   9};
        vecs[3] = '{"ovl_fwd",    8'h10, 8'h12, 9'd6,   13};
        vecs[4] = '{"ovl_back",   8'h12, 8'h10, 9'd6,   13};
        vecs[5] = '{"single",     8'h55, 8'hAA, 9'd1,   3};
        vecs[6] = '{"full_mem",   8'h00, 8'h80, 9'd256, 513};

        rst = 1'b1;
        load = 1'b0;
        bus.Start = 1'b0;
        bus.SrcAddr = '0;
        bus.DstAddr = '0;
        bus.Length = '0;
`ifdef MEM_COPY_FILL_EN
        bus.Fill = 1'b0;
        bus.FillValue = '0;
`endif
        for (int i = 0; i < 256; i++) img[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(bus.Busy), 0);
        check("rst_done",  32'(bus.Done), 0);
        check("rst_rd",    32'(bus.MemRead), 0);
        check("rst_wr",    32'(bus.MemWrite), 0);
        check("rst_addr",  32'(bus.MemAddress), 0);
        check("rst_wdata", 32'(bus.MemWData), 0);
        rst = 1'b0;

        // Basic copy with the known pattern.
        randomize_image();
        for (int i = 0; i < 4; i++) img[8'h10 + i] = pat_a[i];
        load_image();
        do_copy(8'h10, 8'h40, 9'd4, 1'b0, 8'h00, lat, busy_n, rd_n, wr_n, both_n);
        check("basic_done_cycle", lat, 9);
        check("basic_busy_cycles", busy_n, 8);
        for (int i = 0; i < 4; i++) check("basic_byte", 32'(mem[8'h40 + i]), 32'(pat_a[i]));
        compare_mem("basic_mem");

        // Wrap-around copy: read address order and destination bytes.
        randomize_image();
        img[8'hFE] = pat_w[0]; img[8'hFF] = pat_w[1]; img[8'h00] = pat_w[2]; img[8'h01] = pat_w[3];
        load_image();
        base = rd_log.size();
        do_copy(8'hFE, 8'h02, 9'd4, 1'b0, 8'h00, lat, busy_n, rd_n, wr_n, both_n);
        check("wrap_reads", rd_n, 4);
        if (rd_log.size() - base == 4) begin
            for (int i = 0; i < 4; i++) check("wrap_rd_addr", 32'(rd_log[base + i]),
                                              32'(wrap_addr[i]));
        end
        for (int i = 0; i < 4; i++) check("wrap_byte", 32'(mem[8'h02 + i]), 32'(pat_w[i]));

        // Table of directed copies on random memory images.
        foreach (vecs[v]) begin
            randomize_image();
            load_image();
            do_copy(vecs[v].src, vecs[v].dst, vecs[v].len, 1'b0, 8'h00,
                    lat, busy_n, rd_n, wr_n, both_n);
            check({vecs[v].name, "_done_cycle"}, lat, vecs[v].exp_lat);
            check({vecs[v].name, "_reads"}, rd_n, int'(vecs[v].len));
            check({vecs[v].name, "_writes"}, wr_n, int'(vecs[v].len));
            check({vecs[v].name, "_busy"}, busy_n, 2 * int'(vecs[v].len));
            check({vecs[v].name, "_strobe_overlap"}, both_n, 0);
            compare_mem({vecs[v].name, "_mem"});
        end

        // Start while busy is ignored.
        randomize_image();
        load_image();
        @(negedge clk);
        drive_start(8'h20, 8'h60, 9'd4, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        t = cyc;
        d0 = n_done;
        repeat (3) @(negedge clk);
        drive_start(8'h30, 8'h90, 9'd2, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin
                lat = cyc - t + 1;
                break;
            end
        end
        check("busy_start_done_cycle", lat, 9);
        repeat (10) @(negedge clk);
        check("busy_start_done_count", n_done - d0, 1);
        model_copy(8'h20, 8'h60, 9'd4, 1'b0, 8'h00);
        compare_mem("busy_start_mem");

        // Reset in the third READ: only bytes 0 and 1 land, no Done.
        randomize_image();
        load_image();
        @(negedge clk);
        drive_start(8'h00, 8'hC0, 9'd8, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        d0 = n_done;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_outputs", {bus.Busy, bus.Done, bus.MemRead, bus.MemWrite,
                                  bus.MemAddress, bus.MemWData}, 0);
        repeat (5) @(negedge clk);
        check("mid_rst_no_done", n_done - d0, 0);
        model_copy(8'h00, 8'hC0, 9'd2, 1'b0, 8'h00);
        compare_mem("mid_rst_mem");
        do_copy(8'h40, 8'h50, 9'd3, 1'b0, 8'h00, lat, busy_n, rd_n, wr_n, both_n);
        check("post_rst_done_cycle", lat, 7);
        compare_mem("post_rst_mem");

`ifdef MEM_COPY_FILL_EN
        // Fill mode: no reads, one byte per cycle.
        randomize_image();
        load_image();
        do_copy(8'h13, 8'h80, 9'd3, 1'b1, 8'h5A, lat, busy_n, rd_n, wr_n, both_n);
        check("fill_done_cycle", lat, 4);
        check("fill_reads", rd_n, 0);
        check("fill_writes", wr_n, 3);
        for (int i = 0; i < 3; i++) check("fill_byte", 32'(mem[8'h80 + i]), 32'h5A);
        compare_mem("fill_mem");
`endif

        // Randomized requests against the model.
        for (int it = 0; it < 30; it++) begin
            randomize_image();
            load_image();
            src = 8'($urandom);
            dst = 8'($urandom);
            len = ($urandom_range(0, 9) == 0) ? 9'd256 : 9'($urandom_range(0, 40));
            fv  = 8'($urandom);
`ifdef MEM_COPY_FILL_EN
            fill = 1'($urandom_range(0, 1));
`else
            fill = 1'b0;
`endif
            e_lat  = fill ? int'(len) + 1 : 2 * int'(len) + 1;
            e_busy = fill ? int'(len) : 2 * int'(len);
            e_rd   = fill ? 0 : int'(len);
            do_copy(src, dst, len, fill, fv, lat, busy_n, rd_n, wr_n, both_n);
            check("rand_done_cycle", lat, e_lat);
            check("rand_busy", busy_n, e_busy);
            check("rand_reads", rd_n, e_rd);
            check("rand_writes", wr_n, int'(len));
            check("rand_strobe_overlap", both_n, 0);
            compare_mem("rand_mem");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
